mips_instr_encoder: RTL and testbench
=====================================

Name: mips_instr_encoder

Overview:
- Inverse of the core's opcode/func control decoder: packs decoder-level fields (instruction kind, 5-bit ALU_OP, register fields, immediate/target) back into 32-bit MIPS words.
- Streams the words into instruction memory through a write port, so the testbench/boot path can load programs that the core's decoder will round-trip exactly.
- Ready/valid input, 2-entry output buffer, address counter, start/last/done framing.

Parameters:
- ADDR_W, 10, instruction-memory word-address width
- DEPTH, 1024, words available in imem; must be <= 2**ADDR_W

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin load at base_addr; ignored unless IDLE or ERR
- base_addr  in  ADDR_W  first write address, sampled on start
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_kind  in  3  0 R, 1 I-ALU, 2 BRANCH, 3 LW, 4 SW, 5 J, 6 JAL, 7 reserved
- in_alu_op  in  5  decoder ALU_OP code
- in_unsigned  in  1  selects ADDU/SUBU/ADDIU
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields
- in_imm  in  16  immediate/offset
- in_target  in  26  jump target
- in_last  in  1  final instruction of program
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  encoded word
- imem_ready  in  1  write completes when imem_we && imem_ready
- done  out  1  one-cycle pulse after last word written
- err_illegal  out  1  one-cycle pulse: unencodable request accepted
- err_full  out  1  level: write attempted beyond DEPTH-1; held in ERR
- word_count  out  ADDR_W+1  words written since start

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, err_illegal=0, err_full=0, word_count=0, FSM IDLE, buffer empty.
- FSM:
  - IDLE -start-> RUN; on start: addr=base_addr, word_count=0, buffer cleared.
  - RUN: in_ready = buffer not full AND last not yet accepted. Accepting in_last -> DRAIN.
  - DRAIN: in_ready=0; buffer empties -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - Any write whose address equals DEPTH -> ERR instead: err_full=1, write suppressed, buffer flushed.
  - ERR: start -> RUN and clears err_full.
- Latency: word accepted at cycle N with empty buffer -> imem_we=1 at N+1. imem_we/addr/wdata held stable while imem_ready=0. Each completed write: addr+1, word_count+1.
- Buffer: 2 entries; simultaneous push and pop when full is allowed (in_ready stays 1 for a full-throughput stream).
- Encoding, R kind: {000000, rs, rt, rd, shamt, func}. ALU_OP->func map:
  - 00000 XOR 100110; 00001 SLL 000000; 11001 SLLV 000100; 00010 SRL 000010; 11010 SRLV 000110; 00011 SRA 000011
  - 00100 ADD 100000 / ADDU 100001; 00101 SUB 100010 / SUBU 100011
  - 00110 MULT 011000; 00111 DIV 011010; 01000 OR 100101; 01001 NOR 100111; 01010 AND 100100; 01011 SLT 101010; 01100 JR 001000
  - SLL/SRL/SRA force rs=0. Non-shift ops force shamt=0.
- Encoding, I-ALU: {op, rs, rt, imm}:
  - 00100 ADDI 001000 / ADDIU 001001; 01010 ANDI 001100; 00000 XORI 001110; 01000 ORI 001101; 01011 SLTI 001010; 10010 LUI 001111 (rs forced 0).
- Encoding, BRANCH: {op, rs, rt, imm}:
  - 01101 BEQ 000100; 01110 BNE 000101; 01111 BLEZ 000110 (rt=0); 10000 BGTZ 000111 (rt=0); 10001 BGEZ 000001 (rt=00001).
- Encoding, other kinds: LW 100011, SW 101011, ALU_OP ignored. J {000010, target}; JAL {000011, target}.
- Illegal (kind 7, or ALU_OP not in the kind's table): request is accepted, err_illegal pulses the next cycle, nothing is written, addr unchanged. An illegal request with in_last=1 still ends the frame.
- in_valid outside RUN: ignored (in_ready=0).
- Reset mid-operation: immediate return to reset values; partial program abandoned.

Optional Feature:
- MIPS_ENC_ILLEGAL_NOP_EN defined: illegal requests write 32'h00000000 (NOP) at the current address, keeping program addresses aligned; err_illegal still pulses.
- Undefined: illegal requests are dropped as above.

Decomposition:
- Package mips_isa_pkg: opcode/func constants, ALU_OP constants, kind enum (3-bit typedef), NOP constant. The core's decoder shares these.
- Sub-module mips_instr_pack: purely combinational fields -> {word, illegal}.
- mips_instr_encoder holds the FSM, buffer and counters.

Test Plan:
- start base_addr=0x010; R ADD rs=1 rt=2 rd=3 in_unsigned=0 with last -> imem write addr 0x010 data 0x00221820; done pulses; word_count=1.
- I kind ALU_OP 00100 unsigned, rs=0 rt=8 imm=0xFFFF -> 0x2408FFFF. BRANCH BGEZ rs=4 imm=0x0003 -> 0x04810003.
- 4-word stream with imem_ready low 3 cycles on word 2 -> data/addr held stable, in_ready drops when buffer full, no loss or reorder, addresses consecutive.
- kind 7 mid-stream -> err_illegal pulse, next word at the same address (macro off) or NOP written and address+1 (macro on).
- DEPTH=4, base_addr=3, two words -> first written at 3, second triggers err_full=1, ERR state; a new start clears it.
- rst_n asserted during DRAIN -> all outputs zero asynchronously; after release, no write until start.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg
//   Shared MIPS ISA constants: instruction kinds, decoder ALU_OP codes,
//   primary opcodes, R-type function codes, the NOP word, and the state
//   encoding of the program-load encoder.  The core's control decoder
//   uses the same tables, so encoder and decoder round-trip exactly.
//   No ports (package).
package mips_isa_pkg;

  // Instruction kind as presented on in_kind.
  typedef enum logic [2:0] {
    KIND_R      = 3'd0,
    KIND_I      = 3'd1,
    KIND_BRANCH = 3'd2,
    KIND_LW     = 3'd3,
    KIND_SW     = 3'd4,
    KIND_J      = 3'd5,
    KIND_JAL    = 3'd6,
    KIND_RSVD   = 3'd7
  } kind_e;

  // Encoder FSM states, also exported on the debug state output.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } enc_state_e;

  // Decoder ALU_OP codes.
  localparam logic [4:0] ALU_XOR  = 5'b00000;
  localparam logic [4:0] ALU_SLL  = 5'b00001;
  localparam logic [4:0] ALU_SRL  = 5'b00010;
  localparam logic [4:0] ALU_SRA  = 5'b00011;
  localparam logic [4:0] ALU_ADD  = 5'b00100;
  localparam logic [4:0] ALU_SUB  = 5'b00101;
  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;
  localparam logic [4:0] ALU_OR   = 5'b01000;
  localparam logic [4:0] ALU_NOR  = 5'b01001;
  localparam logic [4:0] ALU_AND  = 5'b01010;
  localparam logic [4:0] ALU_SLT  = 5'b01011;
  localparam logic [4:0] ALU_JR   = 5'b01100;
  localparam logic [4:0] ALU_BEQ  = 5'b01101;
  localparam logic [4:0] ALU_BNE  = 5'b01110;
  localparam logic [4:0] ALU_BLEZ = 5'b01111;
  localparam logic [4:0] ALU_BGTZ = 5'b10000;
  localparam logic [4:0] ALU_BGEZ = 5'b10001;
  localparam logic [4:0] ALU_LUI  = 5'b10010;
  localparam logic [4:0] ALU_SLLV = 5'b11001;
  localparam logic [4:0] ALU_SRLV = 5'b11010;

  // Primary opcodes.
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // R-type function codes.
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // I-format word: {op, rs, rt, imm}.
  function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// mips_instr_pack
//   Purely combinational: decoder-level fields -> 32-bit MIPS word plus an
//   illegal flag (reserved kind, or ALU_OP missing from the kind's table).
//   When illegal, word is NOP_WORD.
// Ports:
//   kind[2:0], alu_op[4:0], is_unsigned, rs/rt/rd/shamt[4:0], imm[15:0],
//   target[25:0]   in   request fields
//   word[31:0]     out  encoded instruction
//   illegal        out  request cannot be encoded
module mips_instr_pack
  import mips_isa_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  alu_op,
  input  logic        is_unsigned,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  logic [5:0] func;
  logic [5:0] op;
  logic [4:0] rs_f;
  logic [4:0] rt_f;
  logic [4:0] shamt_f;
  logic [31:0] raw;

  always_comb begin
    func    = F_SLL;
    op      = OP_RTYPE;
    rs_f    = rs;
    rt_f    = rt;
    shamt_f = 5'd0;
    illegal = 1'b0;
    raw     = NOP_WORD;
    case (kind)
      KIND_R: begin
        case (alu_op)
          ALU_XOR:  func = F_XOR;
          // Constant-amount shifts carry shamt and have no rs operand.
          ALU_SLL:  begin func = F_SLL; rs_f = 5'd0; shamt_f = shamt; end
          ALU_SRL:  begin func = F_SRL; rs_f = 5'd0; shamt_f = shamt; end
          ALU_SRA:  begin func = F_SRA; rs_f = 5'd0; shamt_f = shamt; end
          ALU_SLLV: func = F_SLLV;
          ALU_SRLV: func = F_SRLV;
          ALU_ADD:  func = is_unsigned ? F_ADDU : F_ADD;
          ALU_SUB:  func = is_unsigned ? F_SUBU : F_SUB;
          ALU_MULT: func = F_MULT;
          ALU_DIV:  func = F_DIV;
          ALU_OR:   func = F_OR;
          ALU_NOR:  func = F_NOR;
          ALU_AND:  func = F_AND;
          ALU_SLT:  func = F_SLT;
          ALU_JR:   func = F_JR;
          default:  illegal = 1'b1;
        endcase
        raw = {OP_RTYPE, rs_f, rt, rd, shamt_f, func};
      end
      KIND_I: begin
        case (alu_op)
          ALU_ADD: op = is_unsigned ? OP_ADDIU : OP_ADDI;
          ALU_AND: op = OP_ANDI;
          ALU_XOR: op = OP_XORI;
          ALU_OR:  op = OP_ORI;
          ALU_SLT: op = OP_SLTI;
          ALU_LUI: begin op = OP_LUI; rs_f = 5'd0; end
          default: illegal = 1'b1;
        endcase
        raw = pack_i(op, rs_f, rt, imm);
      end
      KIND_BRANCH: begin
        case (alu_op)
          ALU_BEQ:  op = OP_BEQ;
          ALU_BNE:  op = OP_BNE;
          ALU_BLEZ: begin op = OP_BLEZ; rt_f = 5'd0; end
          ALU_BGTZ: begin op = OP_BGTZ; rt_f = 5'd0; end
          // BGEZ lives under REGIMM; rt selects the condition.
          ALU_BGEZ: begin op = OP_REGIMM; rt_f = 5'd1; end
          default:  illegal = 1'b1;
        endcase
        raw = pack_i(op, rs, rt_f, imm);
      end
      KIND_LW:  raw = pack_i(OP_LW, rs, rt, imm);
      KIND_SW:  raw = pack_i(OP_SW, rs, rt, imm);
      KIND_J:   raw = {OP_J, target};
      KIND_JAL: raw = {OP_JAL, target};
      default:  illegal = 1'b1;
    endcase
    word = illegal ? NOP_WORD : raw;
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
//   Accepts decoder-level instruction requests, encodes them with
//   mips_instr_pack and streams the words into instruction memory at
//   consecutive addresses starting at base_addr, with start/last/done framing.
//   Optional build macro: MIPS_ENC_ILLEGAL_NOP_EN -- when defined, illegal
//   requests write a NOP at the current address instead of being dropped.
// Handshakes: a request transfers on a clock edge where in_valid && in_ready;
//   a memory write completes on an edge where imem_we && imem_ready.  While a
//   write is stalled, imem_we/imem_addr/imem_wdata hold their values.  in_ready
//   may depend combinationally on imem_ready (push into a full buffer is
//   allowed in the same cycle a write completes).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, base_addr           begin a load (IDLE or ERR only)
//   in_valid/in_ready          request handshake
//   in_kind .. in_last         request fields
//   imem_we/addr/wdata, imem_ready   instruction-memory write port
//   done                       one-cycle pulse at end of frame
//   err_illegal                one-cycle pulse after an unencodable request
//   err_full                   level: write would pass DEPTH-1
//   word_count                 words written since start
//   dbg_state                  current FSM state (enc_state_e)
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_alu_op,
  input  logic              in_unsigned,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              done,
  output logic              err_illegal,
  output logic              err_full,
  output logic [ADDR_W:0]   word_count,
  output logic [2:0]        dbg_state
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  enc_state_e         state_q, state_d;
  // One extra bit so the address can reach DEPTH and be caught there.
  logic [CW-1:0]      addr_q, addr_d;
  logic [CW-1:0]      wc_q, wc_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [1:0][31:0]   buf_q, buf_d;
  logic               err_illegal_q, err_illegal_d;
  logic               err_full_q, err_full_d;

  logic [31:0] pack_word;
  logic        pack_illegal;
  logic        active, at_limit, wr_pend, pop, accept, push;
  logic [31:0] push_word;

  mips_instr_pack u_pack (
    .kind        (in_kind),
    .alu_op      (in_alu_op),
    .is_unsigned (in_unsigned),
    .rs          (in_rs),
    .rt          (in_rt),
    .rd          (in_rd),
    .shamt       (in_shamt),
    .imm         (in_imm),
    .target      (in_target),
    .word        (pack_word),
    .illegal     (pack_illegal)
  );

  assign active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign at_limit = (addr_q >= DEPTH_C);
  assign wr_pend  = active && (cnt_q != 2'd0);
  assign imem_we  = wr_pend && !at_limit;
  assign pop      = imem_we && imem_ready;
  assign in_ready = (state_q == ST_RUN) && ((cnt_q != 2'd2) || pop);
  assign accept   = in_valid && in_ready;

`ifdef MIPS_ENC_ILLEGAL_NOP_EN
  // Illegal requests occupy a slot as NOP so later addresses stay aligned.
  assign push      = accept;
  assign push_word = pack_illegal ? NOP_WORD : pack_word;
`else
  assign push      = accept && !pack_illegal;
  assign push_word = pack_word;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wc_d          = wc_q;
    cnt_d         = cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    buf_d         = buf_q;
    err_full_d    = err_full_q;
    err_illegal_d = accept && pack_illegal;

    if (push) begin
      buf_d[wr_ptr_q] = push_word;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      addr_d   = addr_q + CW'(1);
      wc_d     = wc_q + CW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          state_d    = ST_RUN;
          addr_d     = {1'b0, base_addr};
          wc_d       = '0;
          cnt_d      = 2'd0;
          rd_ptr_d   = 1'b0;
          wr_ptr_d   = 1'b0;
          err_full_d = 1'b0;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (wr_pend && at_limit) begin
          // Pending write would land past the memory: abandon the frame.
          state_d    = ST_ERR;
          err_full_d = 1'b1;
          cnt_d      = 2'd0;
          rd_ptr_d   = 1'b0;
          wr_ptr_d   = 1'b0;
        end else if (state_q == ST_RUN) begin
          if (accept && in_last) state_d = ST_DRAIN;
        end else if (cnt_q == 2'd0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wc_q          <= '0;
      cnt_q         <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      buf_q         <= '0;
      err_illegal_q <= 1'b0;
      err_full_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wc_q          <= wc_d;
      cnt_q         <= cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      buf_q         <= buf_d;
      err_illegal_q <= err_illegal_d;
      err_full_q    <= err_full_d;
    end
  end

  assign imem_addr   = addr_q[ADDR_W-1:0];
  assign imem_wdata  = buf_q[rd_ptr_q];
  assign done        = (state_q == ST_DONE);
  assign err_illegal = err_illegal_q;
  assign err_full    = err_full_q;
  assign word_count  = wc_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder
//   Directed bench for mips_instr_encoder (default ADDR_W=10, DEPTH=1024).
//   Expected words are hand-encoded constants; memory writes are checked
//   in order against an expected queue of {addr, data}.
module tb_mips_instr_encoder;
  import mips_isa_pkg::*;

  localparam int ADDR_W = 10;
  localparam int EW     = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_kind = 3'd0;
  logic [4:0]        in_alu_op = 5'd0;
  logic              in_unsigned = 1'b0;
  logic [4:0]        in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0, in_shamt = 5'd0;
  logic [15:0]       in_imm = 16'd0;
  logic [25:0]       in_target = 26'd0;
  logic              in_last = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ready = 1'b1;
  logic              done, err_illegal, err_full;
  logic [ADDR_W:0]   word_count;
  logic [2:0]        dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];

  mips_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_alu_op(in_alu_op), .in_unsigned(in_unsigned), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ready(imem_ready),
    .done(done), .err_illegal(err_illegal), .err_full(err_full),
    .word_count(word_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // ---------------- write monitor / scoreboard ----------------
  initial begin
    logic              prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_data;
    logic [EW-1:0]     e;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_we", imem_we, 1);
          check("hold_addr", imem_addr, prev_addr);
          check("hold_data", imem_wdata, prev_data);
        end
        if (imem_we && imem_ready) begin
          if (exp_q.size() == 0) begin
            check("wr_extra", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", imem_addr, e[EW-1:32]);
            check("wr_data", imem_wdata, e[31:0]);
          end
        end
        prev_stall = imem_we && !imem_ready;
        prev_addr  = imem_addr;
        prev_data  = imem_wdata;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [ADDR_W-1:0] b);
    base_addr = b;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic send(input logic [2:0] k, input logic [4:0] op, input logic uns,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic last);
    int n;
    n = 0;
    in_kind = k; in_alu_op = op; in_unsigned = uns;
    in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_imm = imm; in_target = tgt; in_last = last;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_ready", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input logic [ADDR_W:0] exp_wc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check(tag, found, 1);
    check({tag, "_wc"}, word_count, exp_wc);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic seen;
    // Reset state
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_done", done, 0);
    check("rst_err", {err_illegal, err_full}, 0);
    check("rst_wc", word_count, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // in_valid while IDLE is ignored
    in_valid = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Single R ADD with last
    do_start(10'h010);
    expect_wr(10'h010, 32'h0022_1820);
    send(3'd0, 5'b00100, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    check("lat_we", imem_we, 1);
    wait_done("done_add", 1);

    // I-ALU and branch encodings
    do_start(10'h020);
    expect_wr(10'h020, 32'h2408_FFFF);  // ADDIU $8,$0,0xFFFF
    expect_wr(10'h021, 32'h3C05_1234);  // LUI $5,0x1234 (rs forced 0)
    expect_wr(10'h022, 32'h0481_0003);  // BGEZ $4,+3
    send(3'd1, 5'b00100, 1'b1, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
    send(3'd1, 5'b10010, 1'b0, 5'd3, 5'd5, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0);
    send(3'd2, 5'b10001, 1'b0, 5'd4, 5'd9, 5'd0, 5'd0, 16'h0003, 26'h0, 1'b1);
    wait_done("done_ib", 3);

    // 4-word stream, write port stalled for 3 cycles on word 2
    do_start(10'h030);
    expect_wr(10'h030, 32'h0085_3022);  // SUB $6,$4,$5
    expect_wr(10'h031, 32'h8FA8_0010);  // LW $8,16($29)
    expect_wr(10'h032, 32'h0009_5100);  // SLL $10,$9,4 (rs forced 0)
    expect_wr(10'h033, 32'h0810_0040);  // J 0x0100040
    fork
      begin
        send(3'd0, 5'b00101, 1'b0, 5'd4, 5'd5, 5'd6, 5'd3, 16'h0, 26'h0, 1'b0);
        send(3'd3, 5'b11111, 1'b0, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0010, 26'h0, 1'b0);
        send(3'd0, 5'b00001, 1'b0, 5'd7, 5'd9, 5'd10, 5'd4, 16'h0, 26'h0, 1'b0);
        send(3'd5, 5'b00000, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100040, 1'b1);
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          if (imem_we && imem_addr == 10'h030) seen = 1'b1;
        end
        check("stall_sync", seen, 1);
        @(posedge clk); #1;
        imem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        imem_ready = 1'b1;
      end
    join
    wait_done("done_stream", 4);

    // Illegal requests mid-stream
    do_start(10'h040);
    expect_wr(10'h040, 32'h0022_1820);
`ifdef MIPS_ENC_ILLEGAL_NOP_EN
    expect_wr(10'h041, 32'h0000_0000);
    expect_wr(10'h042, 32'h0000_0000);
    expect_wr(10'h043, 32'h0022_1825);
`else
    expect_wr(10'h041, 32'h0022_1825);
`endif
    send(3'd0, 5'b00100, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    check("legal_no_err", err_illegal, 0);
    send(3'd7, 5'b00100, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    check("ill_kind7", err_illegal, 1);
    send(3'd0, 5'b10011, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    check("ill_aluop", err_illegal, 1);
    send(3'd0, 5'b01000, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
`ifdef MIPS_ENC_ILLEGAL_NOP_EN
    wait_done("done_ill", 4);
`else
    wait_done("done_ill", 2);
`endif

    // Write past the last memory word
    do_start(10'h3FF);
    expect_wr(10'h3FF, 32'h0022_1826);  // XOR $3,$1,$2
    send(3'd0, 5'b00000, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    send(3'd0, 5'b01010, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (err_full) seen = 1'b1;
    end
    check("err_full_set", seen, 1);
    check("err_state", dbg_state, ST_ERR);
    check("err_no_we", imem_we, 0);
    check("err_wc", word_count, 1);
    @(posedge clk); #1;
    do_start(10'h080);
    check("err_cleared", err_full, 0);
    check("err_restart", dbg_state, ST_RUN);
    expect_wr(10'h080, 32'h2022_8000);  // ADDI $2,$1,-32768
    send(3'd1, 5'b00100, 1'b0, 5'd1, 5'd2, 5'd0, 5'd0, 16'h8000, 26'h0, 1'b1);
    wait_done("done_recover", 1);

    // Reset while draining
    imem_ready = 1'b0;
    do_start(10'h100);
    send(3'd6, 5'b00000, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000123, 1'b1);
    check("drain_state", dbg_state, ST_DRAIN);
    check("drain_we", imem_we, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_we", imem_we, 0);
    check("arst_addr", imem_addr, 0);
    check("arst_wdata", imem_wdata, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_state", dbg_state, ST_IDLE);
    check("arst_flags", {done, err_illegal, err_full}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    imem_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_we", imem_we, 0);
    check("post_rst_wc", word_count, 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
